// File: rtl/rtcstopwatch_ctrl.sv
// Bus-facing controller for the RTC BCD stopwatch: command strobes, clear/start sequencing,
// auto-stop limit compare and lap capture (lap logic present only with RTCSTOPWATCH_LAP_EN).
module rtcstopwatch_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stb,
   input  logic        i_we,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data,
   input  logic        i_lap,
   input  logic [30:0] i_value,
   input  logic        i_running,
   output logic        o_stall,
   output logic        o_ack,
   output logic [31:0] o_rdata,
   output logic        o_sw_start,
   output logic        o_sw_stop,
   output logic        o_sw_clear,
   output logic [30:0] o_lap,
   output logic        o_int
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CLR = 2'd2, CLRST = 2'd3} state_t;

   state_t      state, state_d;
   logic        clrst_phase, clrst_phase_d;
   logic        start_d, stop_d, clear_d, int_d;
   logic [30:0] limit;
   logic [30:0] prev_value;
   logic [7:0]  lap_cnt;
   logic [31:0] rdata_d;
   logic        accept, ctrl_wr, limit_wr, limit_match;

   assign o_stall     = (state == CLR) || (state == CLRST);
   assign accept      = i_stb && !o_stall;
   assign ctrl_wr     = accept && i_we && (i_addr == 2'd0);
   assign limit_wr    = accept && i_we && (i_addr == 2'd1);
   assign limit_match = (state == RUN) && (limit != 31'd0) &&
                        (i_value != prev_value) && (i_value == limit);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         clrst_phase <= 1'b0;
         o_sw_start  <= 1'b0;
         o_sw_stop   <= 1'b0;
         o_sw_clear  <= 1'b0;
         o_int       <= 1'b0;
         o_ack       <= 1'b0;
         o_rdata     <= 32'd0;
         limit       <= 31'd0;
         prev_value  <= 31'd0;
      end else begin
         state       <= state_d;
         clrst_phase <= clrst_phase_d;
         o_sw_start  <= start_d;
         o_sw_stop   <= stop_d;
         o_sw_clear  <= clear_d;
         o_int       <= int_d;
         o_ack       <= accept;
         prev_value  <= i_value;
         if (accept)
            o_rdata <= rdata_d;
         if (limit_wr)
            limit <= i_data[30:0];
      end
   end

   // Strobes are computed here and registered, so they appear together with the new state.
   always_comb begin
      state_d       = state;
      clrst_phase_d = 1'b0;
      start_d       = 1'b0;
      stop_d        = 1'b0;
      clear_d       = 1'b0;
      int_d         = 1'b0;
      case (state)
         IDLE, RUN: begin
            if (ctrl_wr) begin
               case (i_data[1:0])
                  2'd0: begin
                     stop_d  = 1'b1;
                     state_d = IDLE;
                  end
                  2'd1: begin
                     start_d = 1'b1;
                     state_d = RUN;
                  end
                  2'd2: begin
                     stop_d  = 1'b1;
                     clear_d = 1'b1;
                     state_d = CLR;
                  end
                  default: begin
                     if (state == IDLE) begin
                        clear_d = 1'b1;
                        state_d = CLRST;
                     end
                  end
               endcase
            end else if (limit_match) begin
               stop_d  = 1'b1;
               int_d   = 1'b1;
               state_d = IDLE;
            end
         end
         CLR: state_d = IDLE;
         CLRST: begin
            // First CLRST cycle carries the clear strobe; the second carries the start strobe.
            if (!clrst_phase) begin
               start_d       = 1'b1;
               clrst_phase_d = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdata_d = 32'd0;
      case (i_addr)
         2'd0: rdata_d = {i_running, i_value};
         2'd1: rdata_d = {1'b0, limit};
         2'd2: rdata_d = {1'b0, o_lap};
         default: rdata_d = {24'd0, lap_cnt};
      endcase
   end

`ifdef RTCSTOPWATCH_LAP_EN
   logic lap_take;
   assign lap_take = i_lap && ((state == IDLE) || (state == RUN));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_lap   <= 31'd0;
         lap_cnt <= 8'd0;
      end else if (clear_d) begin
         o_lap   <= 31'd0;
         lap_cnt <= 8'd0;
      end else if (lap_take) begin
         o_lap <= i_value;
         if (lap_cnt != 8'hFF)
            lap_cnt <= lap_cnt + 8'd1;
      end
   end

   logic unused_ok;
   assign unused_ok = i_data[31];
`else
   assign o_lap   = 31'd0;
   assign lap_cnt = 8'd0;

   logic unused_ok;
   assign unused_ok = ^{i_data[31], i_lap};
`endif

endmodule

// File: tb/tb_rtcstopwatch_ctrl.sv
// Directed bench for rtcstopwatch_ctrl; read data is scored through an expected queue.
module tb_rtcstopwatch_ctrl;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_stb;
   logic        i_we;
   logic [1:0]  i_addr;
   logic [31:0] i_data;
   logic        i_lap;
   logic [30:0] i_value;
   logic        i_running;
   logic        o_stall;
   logic        o_ack;
   logic [31:0] o_rdata;
   logic        o_sw_start;
   logic        o_sw_stop;
   logic        o_sw_clear;
   logic [30:0] o_lap;
   logic        o_int;

   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

`ifdef RTCSTOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   localparam logic [31:0] S_IDLE = 32'd0;
   localparam logic [31:0] S_RUN  = 32'd1;
   localparam logic [31:0] S_CLR  = 32'd2;

   rtcstopwatch_ctrl dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_stb      (i_stb),
      .i_we       (i_we),
      .i_addr     (i_addr),
      .i_data     (i_data),
      .i_lap      (i_lap),
      .i_value    (i_value),
      .i_running  (i_running),
      .o_stall    (o_stall),
      .o_ack      (o_ack),
      .o_rdata    (o_rdata),
      .o_sw_start (o_sw_start),
      .o_sw_stop  (o_sw_stop),
      .o_sw_clear (o_sw_clear),
      .o_lap      (o_lap),
      .o_int      (o_int)
   );

   // clock / watchdog
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bounded wait for the controller to leave CLR/CLRST.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (o_stall && n < 10) begin
         step();
         n++;
      end
      chk({tag, "_stall_free"}, 32'(o_stall), 32'd0);
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      i_stb  = 1'b1;
      i_we   = 1'b1;
      i_addr = addr;
      i_data = data;
      step();
      i_stb  = 1'b0;
      i_we   = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      wait_ready(tag);
      exp_q.push_back(exp);
      i_stb  = 1'b1;
      i_we   = 1'b0;
      i_addr = addr;
      step();
      i_stb  = 1'b0;
      chk({tag, "_ack"}, 32'(o_ack), 32'd1);
      if (o_ack)
         chk(tag, o_rdata, exp_q.pop_front());
      else
         void'(exp_q.pop_front());
   endtask

   // BCD increment of centiseconds with carry into seconds.
   function automatic logic [30:0] bcd_inc(input logic [30:0] v);
      logic [30:0] r;
      r = v;
      if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
            else begin
               r[11:8]  = 4'd0;
               r[14:12] = r[14:12] + 3'd1;
            end
         end
      end
      return r;
   endfunction

   initial begin
      logic seen;
      i_reset   = 1'b1;
      i_stb     = 1'b0;
      i_we      = 1'b0;
      i_addr    = 2'd0;
      i_data    = 32'd0;
      i_lap     = 1'b0;
      i_value   = 31'd0;
      i_running = 1'b0;
      step();
      step();
      chk("rst_ack", 32'(o_ack), 32'd0);
      chk("rst_stall", 32'(o_stall), 32'd0);
      chk("rst_start", 32'(o_sw_start), 32'd0);
      chk("rst_stop", 32'(o_sw_stop), 32'd0);
      chk("rst_clear", 32'(o_sw_clear), 32'd0);
      chk("rst_int", 32'(o_int), 32'd0);
      chk("rst_lap", 32'(o_lap), 32'd0);
      chk("rst_rdata", o_rdata, 32'd0);
      chk("rst_state", 32'(dut.state), S_IDLE);
      i_reset = 1'b0;
      step();

      // start
      bus_write(2'd0, 32'd1);
      chk("start_strobe", 32'(o_sw_start), 32'd1);
      chk("start_nostop", 32'(o_sw_stop), 32'd0);
      chk("start_ack", 32'(o_ack), 32'd1);
      chk("start_state", 32'(dut.state), S_RUN);
      step();
      chk("start_pulse_end", 32'(o_sw_start), 32'd0);
      i_running = 1'b1;
      i_value   = 31'h123;
      bus_read("rd_value", 2'd0, {1'b1, 31'h123});
      bus_read("rd_limit_rst", 2'd1, 32'd0);

      // clear-then-start while running is ignored
      bus_write(2'd0, 32'd3);
      chk("run3_start", 32'(o_sw_start), 32'd0);
      chk("run3_stop", 32'(o_sw_stop), 32'd0);
      chk("run3_clear", 32'(o_sw_clear), 32'd0);
      chk("run3_stall", 32'(o_stall), 32'd0);
      chk("run3_ack", 32'(o_ack), 32'd1);
      chk("run3_state", 32'(dut.state), S_RUN);

      // stop
      bus_write(2'd0, 32'd0);
      chk("stop_strobe", 32'(o_sw_stop), 32'd1);
      chk("stop_nostart", 32'(o_sw_start), 32'd0);
      chk("stop_state", 32'(dut.state), S_IDLE);
      i_running = 1'b0;

      // clear then start from idle
      bus_write(2'd0, 32'd3);
      chk("cs1_clear", 32'(o_sw_clear), 32'd1);
      chk("cs1_start", 32'(o_sw_start), 32'd0);
      chk("cs1_stall", 32'(o_stall), 32'd1);
      step();
      chk("cs2_clear", 32'(o_sw_clear), 32'd0);
      chk("cs2_start", 32'(o_sw_start), 32'd1);
      chk("cs2_stall", 32'(o_stall), 32'd1);
      step();
      chk("cs3_start", 32'(o_sw_start), 32'd0);
      chk("cs3_stall", 32'(o_stall), 32'd0);
      chk("cs3_state", 32'(dut.state), S_RUN);
      i_running = 1'b1;

      // stop and clear
      bus_write(2'd0, 32'd2);
      chk("sc_clear", 32'(o_sw_clear), 32'd1);
      chk("sc_stop", 32'(o_sw_stop), 32'd1);
      chk("sc_state", 32'(dut.state), S_CLR);
      step();
      chk("sc_clear_end", 32'(o_sw_clear), 32'd0);
      chk("sc_idle", 32'(dut.state), S_IDLE);
      i_running = 1'b0;

      // limit auto-stop at 5.00 s
      i_value = 31'h495;
      bus_write(2'd1, 32'h0000_0500);
      bus_read("rd_limit", 2'd1, 32'h0000_0500);
      bus_write(2'd0, 32'd1);
      i_running = 1'b1;
      for (int k = 0; k < 40 && i_value != 31'h500; k++) begin
         i_value = bcd_inc(i_value);
         step();
         if (i_value != 31'h500)
            chk("limit_early_int", 32'(o_int), 32'd0);
      end
      chk("limit_stop", 32'(o_sw_stop), 32'd1);
      chk("limit_int", 32'(o_int), 32'd1);
      chk("limit_state", 32'(dut.state), S_IDLE);
      step();
      chk("limit_int_pulse", 32'(o_int), 32'd0);
      i_running = 1'b0;

      // limit 0 never stops
      bus_write(2'd1, 32'd0);
      i_value = 31'h495;
      bus_write(2'd0, 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         i_value = bcd_inc(i_value);
         step();
         seen = seen | o_int | o_sw_stop;
      end
      chk("nolimit_stop_int", 32'(seen), 32'd0);
      chk("nolimit_state", 32'(dut.state), S_RUN);

      // stop write in the same cycle as a limit match
      bus_write(2'd1, 32'h0000_0500);
      i_value = 31'h499;
      bus_write(2'd0, 32'd1);
      i_value = 31'h500;
      bus_write(2'd0, 32'd0);
      chk("same_stop", 32'(o_sw_stop), 32'd1);
      chk("same_int", 32'(o_int), 32'd0);
      chk("same_state", 32'(dut.state), S_IDLE);

      // lap captures
      i_value = 31'h105;
      i_lap   = 1'b1;
      step();
      i_lap = 1'b0;
      chk("lap1", 32'(o_lap), LAP_EN ? 32'h105 : 32'd0);
      i_value = 31'h210;
      i_lap   = 1'b1;
      step();
      i_value = 31'h315;
      step();
      i_lap = 1'b0;
      chk("lap3", 32'(o_lap), LAP_EN ? 32'h315 : 32'd0);
      bus_read("rd_lap", 2'd2, LAP_EN ? 32'h315 : 32'd0);
      bus_read("rd_lapcnt", 2'd3, LAP_EN ? 32'd3 : 32'd0);
      bus_write(2'd0, 32'd2);
      chk("lap_clr", 32'(o_lap), 32'd0);
      bus_read("rd_lapcnt_clr", 2'd3, 32'd0);
      i_lap = 1'b1;
      repeat (260) step();
      i_lap = 1'b0;
      bus_read("rd_lapcnt_sat", 2'd3, LAP_EN ? 32'd255 : 32'd0);

      // reset during clear-then-start
      bus_write(2'd0, 32'd3);
      chk("rcs_clear", 32'(o_sw_clear), 32'd1);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk("rcs_start", 32'(o_sw_start), 32'd0);
      chk("rcs_stop", 32'(o_sw_stop), 32'd0);
      chk("rcs_clear_off", 32'(o_sw_clear), 32'd0);
      chk("rcs_stall", 32'(o_stall), 32'd0);
      chk("rcs_ack", 32'(o_ack), 32'd0);
      chk("rcs_int", 32'(o_int), 32'd0);
      chk("rcs_lap", 32'(o_lap), 32'd0);
      chk("rcs_rdata", o_rdata, 32'd0);
      chk("rcs_state", 32'(dut.state), S_IDLE);
      step();
      chk("rcs_no_late_start", 32'(o_sw_start), 32'd0);
      bus_read("rd_lapcnt_rst", 2'd3, 32'd0);
      bus_read("rd_limit_rst2", 2'd1, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtcstopwatch_ctrl.md
# rtcstopwatch_ctrl

Bus-facing controller for the BCD stopwatch datapath in the RTC core. Decodes bus writes into single-cycle start/stop/clear strobes for the stopwatch, and sequences clear-then-start commands. Provides an auto-stop limit compare and a lap (split) capture register, and returns status on reads. Sits between the RTC register decoder and the stopwatch counter, whose clear input it drives.

## Interface
- No parameters.
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_stb  in  1  bus request strobe; accepted when `!o_stall`
- i_we  in  1  write enable (with i_stb)
- i_addr  in  2  0=control/value, 1=limit, 2=lap value, 3=lap count
- i_data  in  32  write data
- i_lap  in  1  lap capture pulse (e.g. button, already debounced)
- i_value  in  31  stopwatch BCD value (hours[30:24], min[22:16], sec[14:8], centisec[7:0])
- i_running  in  1  stopwatch running flag
- o_stall  out  1  high in states CLR and CLRST
- o_ack  out  1  one cycle after each accepted request
- o_rdata  out  32  registered read data, valid with o_ack
- o_sw_start, o_sw_stop, o_sw_clear  out  1 each  one-cycle command strobes to the stopwatch
- o_lap  out  31  last captured lap value
- o_int  out  1  one-cycle pulse on limit auto-stop

## Operation
- **FSM states:** IDLE (stopped), RUN, CLR, CLRST. Reset → IDLE.
- **Control writes (addr 0, i_data[1:0]):**
  - 0: stop → IDLE.
  - 1: start → RUN.
  - 2: stop and clear → CLR.
  - 3 in IDLE: clear then start → CLRST.
  - 3 in RUN: no effect.
- **Clear sequencing:**
  - CLR asserts o_sw_clear for 1 cycle, then → IDLE.
  - CLRST asserts o_sw_clear for 1 cycle, then asserts o_sw_start on the next cycle and → RUN.
  - Any clear also zeroes o_lap and the lap count.
- **Limit (addr 1):** 31-bit BCD register, reset 0; 0 disables the compare.
  - In RUN with limit≠0, a match fires when i_value changes (differs from its registered previous value) and equals the limit.
  - On a match: o_sw_stop pulse, o_int pulse, → IDLE.
- **Reads:**
  - addr0 = {i_running, i_value}.
  - addr1 = {1'b0, limit}.
  - addr2 = {1'b0, o_lap}.
  - addr3 = {24'b0, lapcount}.
  - Writes to addr 2/3 are ignored (still acked).
- **Priority in the same cycle:** reset > accepted control write > limit match > lap.
- **Lap:** i_lap in RUN or IDLE latches i_value into o_lap and increments an 8-bit lap count, saturating at 255. i_lap is ignored in CLR/CLRST.

## Timing
- All outputs reset to 0. The limit register, lap count and FSM also reset.
- Accepted write in cycle N: o_ack and the command strobe at N+1; the state update is visible at N+1.
- Clear-then-start (write 3 from IDLE at N): o_sw_clear at N+1, o_sw_start at N+2, o_stall high during N+1..N+2.
- Stop/start strobes are never asserted in the same cycle.
- A start write in RUN or a stop write in IDLE still pulses the strobe (harmless, idempotent).
- Limit match detected on the i_value change at cycle N: o_sw_stop and o_int at N+1.
- A control write accepted in that same cycle N overrides the match: no o_int.
- Lap: i_lap at N → o_lap and lap count updated at N+1.
- Reset mid-sequence (CLR/CLRST) aborts: no further strobes, state IDLE the next cycle.

## Configuration
- `RTCSTOPWATCH_LAP_EN` defined: lap capture, lap count and addr 2/3 reads as above.
- Undefined: i_lap ignored, o_lap held at 0, addr 2/3 read 0, lap logic removed.
- The FSM, limit compare and timing are identical in both builds.

## Test plan
- Reset, then write 1 at addr 0 → o_sw_start pulse next cycle, state RUN; read addr 0 returns bit31 = i_running.
- From IDLE, write 3 → o_sw_clear at N+1, o_sw_start at N+2, o_stall high for exactly 2 cycles. In RUN, write 3 → no strobes.
- Write limit 31'h0000_0500 (5.00 s), start, model counts up → at i_value = 0x500, o_sw_stop and o_int one cycle later, state IDLE. Limit 0 → never stops.
- Three i_lap pulses at values 0x105, 0x210, 0x315 → o_lap = 0x315, addr3 reads 3. Write 2 → o_lap = 0, count = 0. 256+ pulses → count holds 255.
- Same-cycle limit match and stop write → only o_sw_stop, no o_int. Reset asserted during CLRST → no o_sw_start, all outputs 0.
- With `RTCSTOPWATCH_LAP_EN` undefined, i_lap pulses → o_lap stays 0, addr2/addr3 read 0.
